cube_state_editor: RTL

Sequencer and state store for manual Rubik's cube entry. Holds all 54 facelet colours, moves an edit cursor over the 3x3 grid of the face on screen, and cycles facelet colours from button presses. It drives the colour and position inputs of the nine on-screen movable squares and the cursor highlight square. It streams the completed cube state to the downstream solver/packer over a valid/ready handshake.

---
 rtl/cube_state_editor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cube_state_editor.sv
// rtl/cube_state_editor.sv - facelet store, edit cursor and export streamer for manual cube entry
module cube_state_editor #(
    parameter logic [8:0] GRID_X0 = 9'd100,
    parameter logic [7:0] GRID_Y0 = 8'd60,
    parameter int         PITCH   = 30
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_colour,
    input  logic        btn_face,
    input  logic        btn_confirm,
    output logic [2:0]  face_sel,
    output logic [26:0] face_colours,
    output logic [8:0]  cursor_x,
    output logic [7:0]  cursor_y,
    output logic        state_valid,
    output logic        busy,
    output logic        reject,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_index,
    output logic [2:0]  out_colour,
    output logic        export_done
);
    typedef enum logic {EDIT = 1'b0, EXPORT = 1'b1} state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  facelet [0:53];
    logic [3:0]  count [0:5];
    logic [2:0]  face;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [6:0]  btns;
    logic [6:0]  prev;
    logic [6:0]  ev;
    logic [6:0]  act;
    logic [5:0]  exp_idx;
    logic [5:0]  base;
    logic [5:0]  cur_idx;
    logic [2:0]  cur_colour;
    logic [2:0]  cur_next;
    logic        sv_q;
    logic        all_nine;
    logic        handshake;
    logic        last_xfer;
    logic        start;

    assign btns = {btn_confirm, btn_face, btn_colour, btn_up, btn_down, btn_left, btn_right};
    assign ev   = btns & ~prev;

    assign base       = 6'(face) * 6'd9;
    assign cur_idx    = base + 6'(row) * 6'd3 + 6'(col);
    assign cur_colour = facelet[cur_idx];
    assign cur_next   = (cur_colour == 3'd6) ? 3'd1 : cur_colour + 3'd1;

    assign handshake = (state == EXPORT) && out_ready;
    assign last_xfer = handshake && (exp_idx == 6'd53);
    assign start     = act[6] && sv_q;

    assign face_sel    = face;
    assign state_valid = sv_q;
    assign out_index   = exp_idx;
    assign out_colour  = facelet[exp_idx];

    // One-hot pick of the single actioned event; nothing is actioned while exporting.
    always_comb begin
        act = '0;
        if (state == EDIT) begin
            if      (ev[6]) act[6] = 1'b1;
            else if (ev[5]) act[5] = 1'b1;
            else if (ev[4]) act[4] = 1'b1;
            else if (ev[3]) act[3] = 1'b1;
            else if (ev[2]) act[2] = 1'b1;
            else if (ev[1]) act[1] = 1'b1;
            else if (ev[0]) act[0] = 1'b1;
        end
    end

    always_comb begin
        all_nine = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (count[k] != 4'd9) all_nine = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= EDIT;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EDIT:    if (start)     state_next = EXPORT;
            EXPORT:  if (last_xfer) state_next = EDIT;
            default: state_next = EDIT;
        endcase
    end

    always_comb begin
        busy      = (state == EXPORT);
        out_valid = (state == EXPORT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            face         <= '0;
            row          <= '0;
            col          <= '0;
            exp_idx      <= '0;
            sv_q         <= 1'b1;
            reject       <= 1'b0;
            export_done  <= 1'b0;
            face_colours <= 27'o111111111;
            cursor_x     <= GRID_X0;
            cursor_y     <= GRID_Y0;
            for (int j = 0; j < 54; j++) facelet[j] <= 3'(j / 9 + 1);
            for (int k = 0; k < 6; k++)  count[k] <= 4'd9;
        end else begin
            prev        <= btns;
            reject      <= act[6] && !sv_q;
            export_done <= last_xfer;
            sv_q        <= all_nine;

            if (start)                       exp_idx <= '0;
            else if (handshake && !last_xfer) exp_idx <= exp_idx + 6'd1;

            if (act[5]) face <= (face == 3'd5) ? 3'd0 : face + 3'd1;
            if (act[3]) row  <= (row == 2'd0) ? 2'd2 : row - 2'd1;
            if (act[2]) row  <= (row == 2'd2) ? 2'd0 : row + 2'd1;
            if (act[1]) col  <= (col == 2'd0) ? 2'd2 : col - 2'd1;
            if (act[0]) col  <= (col == 2'd2) ? 2'd0 : col + 2'd1;

            // Centres are fixed; a colour press there is consumed but changes nothing.
            if (act[4] && !(row == 2'd1 && col == 2'd1)) begin
                facelet[cur_idx] <= cur_next;
                for (int k = 0; k < 6; k++) begin
                    if (3'(k + 1) == cur_colour)    count[k] <= count[k] - 4'd1;
                    else if (3'(k + 1) == cur_next) count[k] <= count[k] + 4'd1;
                end
            end

            for (int i = 0; i < 9; i++) face_colours[3*i +: 3] <= facelet[base + 6'(i)];
            cursor_x <= GRID_X0 + 9'(col) * 9'(PITCH);
            cursor_y <= GRID_Y0 + 8'(row) * 8'(PITCH);
        end
    end
endmodule
